// File: rtl/sd_cmd_ctrl.sv
// SD native-mode CMD line sequencer: SDCLK generation, 48-bit command framing
// with CRC7, response capture (48/136 bit) with timeout and CRC/end-bit checking.
module sd_cmd_ctrl #(
  parameter int CLK_DIV      = 125,
  parameter int INIT_CLKS    = 80,
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CLKS     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_idx_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         timeout_o,
  output logic         crc_err_o,
  output logic [135:0] resp_o,
  output logic         sdclk_o,
  output logic         cmd_o,
  output logic         cmd_oe_o,
  input  logic         cmd_i
);

  localparam int              DW        = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [15:0]     INIT_LAST = 16'(INIT_CLKS - 1);
  localparam logic [15:0]     TOUT_LAST = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0]     NCC_LAST  = 16'(NCC_CLKS - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SEND, ST_WAIT, ST_RECV, ST_CHECK, ST_GAP
  } state_e;

  // CRC7 (x^7+x^3+1, init 0). Leading zeros leave a zero CRC untouched, so
  // shorter messages are simply right-justified in the 120-bit input.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic           sdclk_q, sdclk_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [47:0]    frame_q, frame_d;
  logic [1:0]     type_q, type_d;
  logic [135:0]   resp_q, resp_d;
  logic           cmd_q, cmd_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic           crc_err_q, crc_err_d;

  logic           tc, rise, fall;
  logic [6:0]     tx_crc, rx_crc;
  logic [7:0]     resp_len;

  always_comb begin
    tc      = (div_q == DIV_LAST);
    rise    = tc & ~sdclk_q;
    fall    = tc &  sdclk_q;
    div_d   = tc ? '0 : div_q + 1'b1;
    sdclk_d = sdclk_q ^ tc;
  end

  assign tx_crc   = crc7({80'b0, 2'b01, cmd_idx_i, cmd_arg_i});
  assign rx_crc   = crc7((type_q == 2'b10) ? resp_q[127:8] : {80'b0, resp_q[47:8]});
  assign resp_len = (type_q == 2'b10) ? 8'd136 : 8'd48;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    type_d    = type_q;
    resp_d    = resp_q;
    cmd_d     = cmd_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;

    unique case (state_q)
      ST_INIT: if (rise) begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      // A start coinciding with the done pulse belongs to the old transaction's requester.
      ST_IDLE: if (start_i && !done_q) begin
        type_d    = resp_type_i;
        frame_d   = {2'b01, cmd_idx_i, cmd_arg_i, tx_crc, 1'b1};
        bit_cnt_d = 8'd48;
        timeout_d = 1'b0;
        crc_err_d = 1'b0;
        resp_d    = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: if (fall) begin
        if (bit_cnt_q != 8'd0) begin
          cmd_d     = frame_q[47];
          oe_d      = 1'b1;
          frame_d   = {frame_q[46:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 8'd1;
        end else begin
          cmd_d   = 1'b1;
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = (type_q == 2'b00) ? ST_GAP : ST_WAIT;
        end
      end
      ST_WAIT: if (rise) begin
        if (!cmd_i) begin
          resp_d    = {resp_q[134:0], 1'b0};
          bit_cnt_d = 8'd1;
          state_d   = ST_RECV;
        end else if (cnt_q == TOUT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_GAP;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_RECV: if (rise) begin
        resp_d = {resp_q[134:0], cmd_i};
        if (bit_cnt_q + 8'd1 == resp_len) state_d = ST_CHECK;
        else bit_cnt_d = bit_cnt_q + 8'd1;
      end
      ST_CHECK: begin
        crc_err_d = ~resp_q[0] | ((type_q == 2'b01 || type_q == 2'b10) && (rx_crc != resp_q[7:1]));
        cnt_d     = '0;
        state_d   = ST_GAP;
      end
      ST_GAP: if (rise) begin
        if (cnt_q == NCC_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_INIT;
      div_q     <= '0;
      sdclk_q   <= 1'b0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      resp_q    <= '0;
      cmd_q     <= 1'b1;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sdclk_q   <= sdclk_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      resp_q    <= resp_d;
      cmd_q     <= cmd_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
    end
  end

  // NOTE: frame and type are always loaded before use, so they carry no reset.
  always_ff @(posedge clk_i) begin
    frame_q <= frame_d;
    type_q  <= type_d;
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign crc_err_o = crc_err_q;
  assign resp_o    = resp_q;
  assign sdclk_o   = sdclk_q;
  assign cmd_o     = cmd_q;
  assign cmd_oe_o  = oe_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Bench for sd_cmd_ctrl: card model on the CMD line plus a CRC7 long-division reference.
module tb_sd_cmd_ctrl;

  localparam int CLK_DIV = 2;

  logic         clk = 1'b0;
  logic         rst_i, start_i, cmd_i;
  logic [5:0]   cmd_idx_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   resp_type_i;
  logic         busy_o, done_o, timeout_o, crc_err_o, sdclk_o, cmd_o, cmd_oe_o;
  logic [135:0] resp_o;

  int checks = 0;
  int passed = 0;
  logic sd_prev = 1'b0, sd_cur = 1'b0;
  bit rise, fall;

  sd_cmd_ctrl #(.CLK_DIV(CLK_DIV), .INIT_CLKS(80), .RESP_TIMEOUT(64), .NCC_CLKS(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cmd_idx_i(cmd_idx_i),
    .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .crc_err_o(crc_err_o), .resp_o(resp_o), .sdclk_o(sdclk_o),
    .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o), .cmd_i(cmd_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    sd_prev = sd_cur;
    sd_cur  = sdclk_o;
    rise    = !sd_prev && sd_cur;
    fall    = sd_prev && !sd_cur;
  endtask

  // Remainder of data(x)*x^7 divided by x^7+x^3+1, by plain long division.
  function automatic logic [6:0] ref_crc7(input logic [119:0] data, input int nbits);
    logic [126:0] r;
    r = {data, 7'b0};
    for (int i = nbits + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, ref_crc7({80'b0, body}, 40), 1'b1};
  endfunction

  function automatic logic exp_crc_err(input logic [1:0] typ, input logic [135:0] r);
    logic bad;
    bad = !r[0];
    if (typ == 2'b01) bad = bad | (ref_crc7({80'b0, r[47:8]}, 40) != r[7:1]);
    if (typ == 2'b10) bad = bad | (ref_crc7(r[127:8], 120) != r[7:1]);
    return bad;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 4000) begin step(); n++; end
    check({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic launch(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                        input string tag);
    cmd_idx_i = idx; cmd_arg_i = arg; resp_type_i = typ; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check({tag, "_busy"}, busy_o, 1'b1);
    check({tag, "_clr"}, {timeout_o, crc_err_o, |resp_o}, 3'b000);
  endtask

  // Captures the frame as a card would (on SDCLK rises), answers with rbits, checks the outcome.
  task automatic run_txn(input string tag, input logic [1:0] typ, input logic [47:0] exp_frame,
                         input bit reply, input logic [135:0] rbits, input int delay,
                         input bit glitch, input bit start_at_done, input int exp_rises);
    logic [47:0]  frame = '0;
    logic         prev_cmd = cmd_o;
    int           nbits = 0, bad_edge = 0, oe_bad = 0, n = 0, rises = 0, gstate = 0;
    int           len = (typ == 2'b10) ? 136 : 48;
    int           ptr;
    bit           done_seen = 0;
    logic         exp_to, exp_crc;
    logic [135:0] exp_resp;

    while (!(nbits == 48 && cmd_oe_o === 1'b0) && n < 3000) begin
      step(); n++;
      if (gstate == 1) begin start_i = 1'b0; gstate = 2; end
      if (cmd_o !== prev_cmd && !fall) bad_edge++;
      prev_cmd = cmd_o;
      if (rise && cmd_oe_o) begin frame = {frame[46:0], cmd_o}; nbits++; end
      if (glitch && gstate == 0 && nbits == 10) begin
        cmd_idx_i = 6'h3F; cmd_arg_i = 32'hFFFF_FFFF; resp_type_i = 2'b10;
        start_i = 1'b1; gstate = 1;
      end
    end
    check({tag, "_frame"}, frame, exp_frame);

    ptr = len; n = 0;
    while (!done_seen && n < 4000) begin
      step(); n++;
      if (cmd_o !== prev_cmd && !fall) bad_edge++;
      prev_cmd = cmd_o;
      if (cmd_oe_o) oe_bad++;
      if (rise) rises++;
      if (fall && reply && typ != 2'b00) begin
        if (rises >= delay && ptr > 0) begin ptr--; cmd_i = rbits[ptr]; end
        else if (ptr == 0) cmd_i = 1'b1;
      end
      if (done_o) done_seen = 1;
    end
    cmd_i = 1'b1;

    exp_to   = (typ != 2'b00) && !reply;
    exp_crc  = (typ != 2'b00) && reply && exp_crc_err(typ, rbits);
    exp_resp = (typ == 2'b00 || !reply) ? 136'b0 :
               (typ == 2'b10) ? rbits : {88'b0, rbits[47:0]};
    check({tag, "_done"}, {done_seen, busy_o}, 2'b10);
    check({tag, "_flags"}, {timeout_o, crc_err_o}, {exp_to, exp_crc});
    check({tag, "_resp"}, resp_o, exp_resp);
    check({tag, "_line"}, {bad_edge != 0, oe_bad != 0}, 2'b00);
    if (exp_rises > 0) check({tag, "_rises"}, rises, exp_rises);

    if (start_at_done) start_i = 1'b1;
    step();
    start_i = 1'b0;
    check({tag, "_after"}, {done_o, busy_o, timeout_o, crc_err_o}, {2'b00, exp_to, exp_crc});
  endtask

  logic [5:0]   idx;
  logic [31:0]  arg;
  logic [1:0]   typ;
  logic [119:0] body;
  logic [135:0] rb;
  int           n, rises, nb, delay;
  bit           oe_seen, done_seen, reply;

  initial begin
    rst_i = 1'b1; start_i = 1'b1; cmd_idx_i = 6'd0; cmd_arg_i = '0; resp_type_i = 2'b00;
    cmd_i = 1'b1;
    repeat (3) step();
    check("reset_flags", {busy_o, done_o, timeout_o, crc_err_o, sdclk_o, cmd_o, cmd_oe_o},
          7'b1000010);
    check("reset_resp", resp_o, 136'b0);

    // Init with start held high: no command may begin before 80 SDCLK rises.
    rst_i = 1'b0; n = 0; rises = 0; oe_seen = 0;
    while (busy_o !== 1'b0 && n < 5000) begin
      step(); n++;
      if (rise) rises++;
      if (cmd_oe_o) oe_seen = 1;
    end
    check("init_rises", rises, 80);
    check("init_oe", oe_seen, 1'b0);
    step();
    start_i = 1'b0;
    check("cmd0_busy", busy_o, 1'b1);
    run_txn("cmd0", 2'b00, 48'h4000_0000_0095, 0, '0, 0, 0, 1, 8);

    wait_idle("cmd8");
    launch(6'd8, 32'h0000_01AA, 2'b01, "cmd8");
    run_txn("cmd8", 2'b01, 48'h4800_0001_AA87, 1, {88'b0, 48'h0800_0001_AA13}, 5, 0, 0, 0);

    wait_idle("cmd8bad");
    launch(6'd8, 32'h0000_01AA, 2'b01, "cmd8bad");
    run_txn("cmd8bad", 2'b01, 48'h4800_0001_AA87, 1, {88'b0, 48'h0800_0001_AA15}, 5, 1, 0, 0);

    wait_idle("cmd55");
    launch(6'd55, 32'h0, 2'b01, "cmd55");
    run_txn("cmd55", 2'b01, make_frame(6'd55, 32'h0), 0, '0, 0, 0, 0, 72);

    wait_idle("cmd0b");
    launch(6'd0, 32'h0, 2'b00, "cmd0b");
    run_txn("cmd0b", 2'b00, 48'h4000_0000_0095, 0, '0, 0, 0, 0, 8);

    body = {$urandom, $urandom, $urandom, 24'($urandom)};
    rb   = {8'h3F, body, ref_crc7(body, 120), 1'b1};
    wait_idle("r2");
    launch(6'd2, 32'h0, 2'b10, "r2");
    run_txn("r2", 2'b10, make_frame(6'd2, 32'h0), 1, rb, 3, 0, 0, 0);

    wait_idle("r3");
    launch(6'd41, 32'h40FF_8000, 2'b11, "r3");
    run_txn("r3", 2'b11, make_frame(6'd41, 32'h40FF_8000), 1, {88'b0, 48'h3F00_FF80_00FF},
            2, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      typ = 2'($urandom_range(0, 3));
      idx = 6'($urandom);
      arg = $urandom;
      rb  = {8'h00, $urandom, $urandom, $urandom, $urandom};
      if (typ == 2'b10) begin
        rb[135:128] = 8'h3F;
        rb[7:1]     = ref_crc7(rb[127:8], 120);
      end else begin
        rb[135:46]  = '0;
        rb[7:1]     = ref_crc7({80'b0, rb[47:8]}, 40);
      end
      rb[0] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(0, 7);
        rb[nb] = ~rb[nb];
      end
      reply = ($urandom_range(0, 9) != 0);
      delay = $urandom_range(1, 20);
      wait_idle("rnd");
      launch(idx, arg, typ, "rnd");
      run_txn("rnd", typ, make_frame(idx, arg), reply, rb, delay, 0, 0, 0);
    end

    // Reset in the middle of SEND aborts without a done pulse and re-runs INIT.
    wait_idle("rst");
    launch(6'd17, 32'h0000_1000, 2'b01, "rst");
    nb = 0; n = 0;
    while (nb < 20 && n < 2000) begin
      step(); n++;
      if (rise && cmd_oe_o) nb++;
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_abort", {cmd_oe_o, busy_o, done_o}, 3'b010);
    n = 0; rises = 0; done_seen = 0;
    while (busy_o !== 1'b0 && n < 5000) begin
      step(); n++;
      if (rise) rises++;
      if (done_o) done_seen = 1;
    end
    check("rst_reinit_rises", rises, 80);
    check("rst_no_done", done_seen, 1'b0);

    step();
    launch(6'd0, 32'h0, 2'b00, "post_rst");
    run_txn("post_rst", 2'b00, 48'h4000_0000_0095, 0, '0, 0, 0, 0, 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
